// File: rtl/tile_scan_controller.sv
// Walks micro-tiles in order: settle in reset, run with a latched stimulus, capture, stream the result.
// Define TILE_SCAN_SIG_EN to build the rotate-xor scan signature on 'sig'; otherwise sig is tied low.
module tile_scan_controller #(
    parameter int NUM_TILES     = 4,
    parameter int SEL_W         = 2,
    parameter int SETTLE_CYCLES = 8,
    parameter int RUN_CYCLES    = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       stim,
    output logic [SEL_W-1:0] tile_sel,
    output logic             tile_rst_n,
    output logic [7:0]       tile_ui,
    input  logic [7:0]       tile_uo,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SEL_W-1:0] res_tile,
    output logic [7:0]       res_data,
    output logic             busy,
    output logic             done,
    output logic [7:0]       sig
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RUN,
        CAPTURE,
        EMIT,
        FINISH
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_TILE   = SEL_W'(NUM_TILES - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [SEL_W-1:0] index;
    logic [7:0]       stim_q;

    // tile_sel only moves on entry to SETTLE, when tile_rst_n is already low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            index      <= '0;
            stim_q     <= '0;
            tile_sel   <= '0;
            tile_rst_n <= 1'b0;
            tile_ui    <= '0;
            res_valid  <= 1'b0;
            res_tile   <= '0;
            res_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        stim_q   <= stim;
                        index    <= '0;
                        tile_sel <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (count == SETTLE_LAST) begin
                        count      <= '0;
                        tile_rst_n <= 1'b1;
                        tile_ui    <= stim_q;
                        state      <= RUN;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RUN: begin
                    if (count == RUN_LAST) begin
                        count <= '0;
                        state <= CAPTURE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                CAPTURE: begin
                    res_data   <= tile_uo;
                    res_tile   <= index;
                    res_valid  <= 1'b1;
                    tile_rst_n <= 1'b0;
                    tile_ui    <= '0;
                    state      <= EMIT;
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (index == LAST_TILE) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            index    <= index + 1'b1;
                            tile_sel <= index + 1'b1;
                            count    <= '0;
                            state    <= SETTLE;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TILE_SCAN_SIG_EN
    logic [7:0] sig_q;

    // Signature folds in each result as it is handed off, so it settles before done.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else if (state == IDLE && start) begin
            sig_q <= '0;
        end else if (state == EMIT && res_valid && res_ready) begin
            sig_q <= {sig_q[6:0], sig_q[7]} ^ res_data;
        end
    end

    assign sig = sig_q;
`else
    assign sig = 8'h00;
`endif

endmodule
